// File: rtl/mem_pkg.sv
// Shared widths and FSM encoding for the memory responder.
package mem_pkg;

   localparam int unsigned MemAddrW = 8;
   localparam int unsigned MemDataW = 16;

   typedef enum logic {
      StClear,
      StServe
   } mem_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// CPU and program-loader signal bundle between the processor/loader side and the memory responder.
interface mem_responder_if #(
   parameter int unsigned AddrW = mem_pkg::MemAddrW,
   parameter int unsigned DataW = mem_pkg::MemDataW
);

   logic [AddrW-1:0] cpu_addr;
   logic             cpu_re;
   logic             cpu_we;
   logic [DataW-1:0] cpu_wdata;
   logic [DataW-1:0] cpu_rdata;

   logic             load_valid;
   logic             load_ready;
   logic [AddrW-1:0] load_addr;
   logic [DataW-1:0] load_data;

   modport master (
      output cpu_addr, cpu_re, cpu_we, cpu_wdata, load_valid, load_addr, load_data,
      input  cpu_rdata, load_ready
   );

   modport slave (
      input  cpu_addr, cpu_re, cpu_we, cpu_wdata, load_valid, load_addr, load_data,
      output cpu_rdata, load_ready
   );

endinterface

// File: rtl/mem_rd_pipe.sv
// Read-response delay line: Stages valid+data shift stages feeding a holding output register
// that only updates when a valid response reaches it.
module mem_rd_pipe #(
   parameter int unsigned DataW  = 16,
   parameter int unsigned Stages = 0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid_i,
   input  logic [DataW-1:0] in_data_i,
   output logic [DataW-1:0] rdata_o
);

   logic             out_valid;
   logic [DataW-1:0] out_data;
   logic [DataW-1:0] rdata_q;

   if (Stages == 0) begin : g_direct
      assign out_valid = in_valid_i;
      assign out_data  = in_data_i;
   end else begin : g_shift
      logic [Stages-1:0] valid_q;
      logic [DataW-1:0]  data_q [Stages];

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < Stages; i++) begin
               data_q[i] <= '0;
            end
         end else begin
            valid_q[0] <= in_valid_i;
            data_q[0]  <= in_data_i;
            for (int i = 1; i < Stages; i++) begin
               valid_q[i] <= valid_q[i-1];
               data_q[i]  <= data_q[i-1];
            end
         end
      end

      assign out_valid = valid_q[Stages-1];
      assign out_data  = data_q[Stages-1];
   end

   // Holds the last returned word between reads so the CPU never sees a bubble value.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q <= '0;
      end else if (out_valid) begin
         rdata_q <= out_data;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder: clears itself after reset, then serves CPU reads/writes with a
// fixed read latency and accepts loader writes on cycles the CPU leaves idle.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned AddrW       = MemAddrW,
   parameter int unsigned DataW       = MemDataW,
   parameter int unsigned ReadLatency = 1
) (
   input  logic            clock,
   input  logic            reset_n,
   mem_responder_if.slave  bus,
   output logic            init_done,
   output logic            access_err
);

   localparam int unsigned Depth = 1 << AddrW;

   mem_state_e       state_q, state_d;
   logic [AddrW-1:0] clr_cnt_q, clr_cnt_d;
   logic             access_err_q, access_err_d;

   logic             cpu_req;
   logic             serving;
   logic             wr_en;
   logic [AddrW-1:0] wr_addr;
   logic [DataW-1:0] wr_data;
   logic             rd_valid;
   logic [DataW-1:0] rd_data;

   logic [DataW-1:0] mem_q [Depth];

   assign cpu_req        = bus.cpu_re | bus.cpu_we;
   assign serving        = (state_q == StServe);
   assign bus.load_ready = serving & ~cpu_req;

   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      access_err_d = access_err_q;
      unique case (state_q)
         StClear: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (cpu_req) begin
               access_err_d = 1'b1;
            end
            if (clr_cnt_q == AddrW'(Depth - 1)) begin
               state_d = StServe;
            end
         end
         StServe: begin
            state_d = StServe;
         end
         default: begin
            state_d = StClear;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StClear;
         clr_cnt_q    <= '0;
         access_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         access_err_q <= access_err_d;
      end
   end

   // Single write port: sweep beats CPU, CPU beats loader.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = bus.cpu_addr;
      wr_data = bus.cpu_wdata;
      if (!serving) begin
         wr_en   = 1'b1;
         wr_addr = clr_cnt_q;
         wr_data = '0;
      end else if (bus.cpu_we) begin
         wr_en = 1'b1;
      end else if (bus.load_valid && bus.load_ready) begin
         wr_en   = 1'b1;
         wr_addr = bus.load_addr;
         wr_data = bus.load_data;
      end
   end

   // Array is deliberately not reset; the clear sweep zeroes it.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Asynchronous array read sampled on the request edge gives read-first collisions.
   assign rd_valid = serving & bus.cpu_re;
   assign rd_data  = mem_q[bus.cpu_addr];

   mem_rd_pipe #(
      .DataW  (DataW),
      .Stages (ReadLatency - 1)
   ) u_rd_pipe (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid_i (rd_valid),
      .in_data_i  (rd_data),
      .rdata_o    (bus.cpu_rdata)
   );

   assign init_done  = serving;
   assign access_err = access_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: latency-1 and latency-3 instances share one stimulus stream and are
// checked every cycle against a queue-based behavioural model plus directed literal checks.
module tb_mem_responder;
   import mem_pkg::*;

   localparam int unsigned Depth = 1 << MemAddrW;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic init_done1, init_done3, access_err1, access_err3;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   mem_responder_if bus1 ();
   mem_responder_if bus3 ();

   assign bus3.cpu_addr   = bus1.cpu_addr;
   assign bus3.cpu_re     = bus1.cpu_re;
   assign bus3.cpu_we     = bus1.cpu_we;
   assign bus3.cpu_wdata  = bus1.cpu_wdata;
   assign bus3.load_valid = bus1.load_valid;
   assign bus3.load_addr  = bus1.load_addr;
   assign bus3.load_data  = bus1.load_data;

   mem_responder #(.ReadLatency(1)) dut1 (
      .clock      (clock),
      .reset_n    (reset_n),
      .bus        (bus1),
      .init_done  (init_done1),
      .access_err (access_err1)
   );

   mem_responder #(.ReadLatency(3)) dut3 (
      .clock      (clock),
      .reset_n    (reset_n),
      .bus        (bus3),
      .init_done  (init_done3),
      .access_err (access_err3)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   // Model: memory array, remaining sweep words, and timestamped response queues per latency.
   typedef struct {
      int          due;
      logic [15:0] data;
   } resp_t;

   resp_t       q1[$];
   resp_t       q3[$];
   logic [15:0] m_mem [Depth];
   int          m_clr_left = 0;
   int          edge_n     = 0;
   logic [15:0] m_rd1      = '0;
   logic [15:0] m_rd3      = '0;
   bit          m_err      = 1'b0;

   initial forever begin
      resp_t r;
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
         m_clr_left = Depth;
         m_err      = 1'b0;
         m_rd1      = '0;
         m_rd3      = '0;
         q1.delete();
         q3.delete();
      end else begin
         edge_n++;
         if (m_clr_left > 0) begin
            m_mem[Depth - m_clr_left] = '0;
            m_clr_left--;
            if (bus1.cpu_re || bus1.cpu_we) m_err = 1'b1;
         end else begin
            if (bus1.cpu_re) begin
               r.data = m_mem[bus1.cpu_addr];
               r.due  = edge_n;
               q1.push_back(r);
               r.due  = edge_n + 2;
               q3.push_back(r);
            end
            if (bus1.cpu_we) m_mem[bus1.cpu_addr] = bus1.cpu_wdata;
            else if (bus1.load_valid && !bus1.cpu_re) m_mem[bus1.load_addr] = bus1.load_data;
         end
         while (q1.size() > 0 && q1[0].due == edge_n) begin
            m_rd1 = q1[0].data;
            q1.delete(0);
         end
         while (q3.size() > 0 && q3[0].due == edge_n) begin
            m_rd3 = q3[0].data;
            q3.delete(0);
         end
      end
   end

   // Per-cycle compare, late in the cycle after inputs and outputs have settled.
   initial forever begin
      bit exp_ready;
      @(negedge clock);
      #4;
      if (chk_en) begin
         exp_ready = (m_clr_left == 0) && !bus1.cpu_re && !bus1.cpu_we;
         check("model_rdata_l1", bus1.cpu_rdata, m_rd1);
         check("model_rdata_l3", bus3.cpu_rdata, m_rd3);
         check("model_init_l1", 16'(init_done1), 16'(m_clr_left == 0));
         check("model_init_l3", 16'(init_done3), 16'(m_clr_left == 0));
         check("model_err_l1", 16'(access_err1), 16'(m_err));
         check("model_err_l3", 16'(access_err3), 16'(m_err));
         check("model_ready_l1", 16'(bus1.load_ready), 16'(exp_ready));
         check("model_ready_l3", 16'(bus3.load_ready), 16'(exp_ready));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exhausted, want completion");
      $fatal(1);
   end

   initial begin
      logic [15:0] ldv [4];
      ldv[0] = 16'h1A21;
      ldv[1] = 16'h2B42;
      ldv[2] = 16'h0000;
      ldv[3] = 16'hFFFF;

      bus1.cpu_addr   = '0;
      bus1.cpu_re     = 1'b0;
      bus1.cpu_we     = 1'b0;
      bus1.cpu_wdata  = '0;
      bus1.load_valid = 1'b0;
      bus1.load_addr  = '0;
      bus1.load_data  = '0;

      repeat (2) @(negedge clock);
      chk_en = 1'b1;
      check("rst_rdata", bus1.cpu_rdata, 16'h0000);
      check("rst_init", 16'(init_done1), 16'd0);
      check("rst_err", 16'(access_err1), 16'd0);
      check("rst_ready", 16'(bus1.load_ready), 16'd0);

      // Reset then idle: sweep length
      reset_n = 1'b1;
      for (int k = 1; k <= 256; k++) begin
         @(negedge clock);
         if (k == 255) check("sweep_init_low_255", 16'(init_done1), 16'd0);
         if (k == 256) begin
            check("sweep_init_high_256", 16'(init_done1), 16'd1);
            check("sweep_init_high_256_l3", 16'(init_done3), 16'd1);
         end
      end
      for (int a = 0; a < int'(Depth); a++) begin
         bus1.cpu_re   = 1'b1;
         bus1.cpu_addr = 8'(a);
         @(negedge clock);
      end
      check("sweep_rd255", bus1.cpu_rdata, 16'h0000);
      bus1.cpu_re = 1'b0;
      #1;
      check("idle_ready", 16'(bus1.load_ready), 16'd1);
      repeat (3) @(negedge clock);

      // Loader burst
      bus1.load_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus1.load_addr = 8'(i);
         bus1.load_data = ldv[i];
         #1;
         check("burst_ready", 16'(bus1.load_ready), 16'd1);
         @(negedge clock);
      end
      bus1.load_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus1.cpu_re   = 1'b1;
         bus1.cpu_addr = 8'(i);
         @(negedge clock);
         check("burst_rd", bus1.cpu_rdata, ldv[i]);
      end
      bus1.cpu_re = 1'b0;
      @(negedge clock);

      // Arbitration: CPU read wins over loader at the same address
      bus1.cpu_re     = 1'b1;
      bus1.cpu_addr   = 8'd5;
      bus1.load_valid = 1'b1;
      bus1.load_addr  = 8'd5;
      bus1.load_data  = 16'hBEEF;
      #1;
      check("arb_ready_low", 16'(bus1.load_ready), 16'd0);
      check("arb_ready_low_l3", 16'(bus3.load_ready), 16'd0);
      @(negedge clock);
      check("arb_rd_old", bus1.cpu_rdata, 16'h0000);
      bus1.cpu_re = 1'b0;
      #1;
      check("arb_ready_idle", 16'(bus1.load_ready), 16'd1);
      @(negedge clock);
      bus1.load_valid = 1'b0;
      bus1.cpu_re     = 1'b1;
      bus1.cpu_addr   = 8'd5;
      @(negedge clock);
      check("arb_rd5", bus1.cpu_rdata, 16'hBEEF);
      bus1.cpu_re = 1'b0;

      // Read-first collision
      bus1.load_valid = 1'b1;
      bus1.load_addr  = 8'd9;
      bus1.load_data  = 16'h0011;
      @(negedge clock);
      bus1.load_valid = 1'b0;
      bus1.cpu_re     = 1'b1;
      bus1.cpu_we     = 1'b1;
      bus1.cpu_addr   = 8'd9;
      bus1.cpu_wdata  = 16'h00AA;
      @(negedge clock);
      check("rf_old", bus1.cpu_rdata, 16'h0011);
      bus1.cpu_we = 1'b0;
      @(negedge clock);
      check("rf_new", bus1.cpu_rdata, 16'h00AA);
      bus1.cpu_re = 1'b0;
      repeat (3) @(negedge clock);

      // Latency 3 pipelined reads
      bus1.cpu_re   = 1'b1;
      bus1.cpu_addr = 8'd1;
      @(negedge clock);
      check("l3_edge_n", bus3.cpu_rdata, 16'h00AA);
      bus1.cpu_addr = 8'd2;
      @(negedge clock);
      check("l3_edge_n1", bus3.cpu_rdata, 16'h00AA);
      bus1.cpu_addr = 8'd3;
      @(negedge clock);
      check("l3_edge_n2", bus3.cpu_rdata, 16'h2B42);
      bus1.cpu_re = 1'b0;
      @(negedge clock);
      check("l3_edge_n3", bus3.cpu_rdata, 16'h0000);
      @(negedge clock);
      check("l3_edge_n4", bus3.cpu_rdata, 16'hFFFF);

      // Reset abort mid-pipeline
      bus1.cpu_re   = 1'b1;
      bus1.cpu_addr = 8'd1;
      @(negedge clock);
      bus1.cpu_addr = 8'd3;
      @(negedge clock);
      reset_n     = 1'b0;
      bus1.cpu_re = 1'b0;
      #1;
      check("abort_rdata_l1", bus1.cpu_rdata, 16'h0000);
      check("abort_rdata_l3", bus3.cpu_rdata, 16'h0000);
      check("abort_init_l1", 16'(init_done1), 16'd0);
      check("abort_init_l3", 16'(init_done3), 16'd0);
      repeat (2) @(negedge clock);

      // Access during the restarted sweep
      reset_n = 1'b1;
      for (int k = 1; k <= 256; k++) begin
         @(negedge clock);
         if (k == 9) begin
            check("clr_err_before", 16'(access_err1), 16'd0);
            bus1.cpu_we    = 1'b1;
            bus1.cpu_addr  = 8'd3;
            bus1.cpu_wdata = 16'h1234;
         end
         if (k == 10) begin
            bus1.cpu_we = 1'b0;
            check("clr_err_set", 16'(access_err1), 16'd1);
         end
         if (k == 255) check("restart_init_low_255", 16'(init_done1), 16'd0);
         if (k == 256) begin
            check("restart_init_high_256", 16'(init_done1), 16'd1);
            check("clr_err_sticky", 16'(access_err1), 16'd1);
         end
      end
      bus1.cpu_re   = 1'b1;
      bus1.cpu_addr = 8'd3;
      @(negedge clock);
      check("clr_rd3", bus1.cpu_rdata, 16'h0000);
      bus1.cpu_re = 1'b0;
      repeat (3) @(negedge clock);
      check("clr_err_final", 16'(access_err1), 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
